// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: MISR FSM states, default polynomial and pattern
// count, and the MISR step function reused by the compactor and its checkers.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } misr_state_t;

  localparam logic [7:0] POLY_8        = 8'h1D;
  localparam int         PAT_COUNT_DEF = 16;

  // Widest signature the generic step function can handle.
  localparam int MISR_MAX_BITS = 64;

  // One Galois MISR step on the low 'width' bits: shift left, fold the
  // outgoing MSB back through the taps, then absorb the response word.
  function automatic logic [MISR_MAX_BITS-1:0] misr_step(
    input logic [MISR_MAX_BITS-1:0] s,
    input logic [MISR_MAX_BITS-1:0] r,
    input logic [MISR_MAX_BITS-1:0] poly,
    input int                       width
  );
    logic [MISR_MAX_BITS-1:0] mask;
    logic [MISR_MAX_BITS-1:0] nxt;
    logic                     msb;
    mask = (width >= MISR_MAX_BITS) ? '1
         : ((MISR_MAX_BITS'(1) << width) - MISR_MAX_BITS'(1));
    msb  = |(s & (MISR_MAX_BITS'(1) << (width - 1)));
    nxt  = (s << 1) & mask;
    if (msb) nxt = nxt ^ poly;
    return (nxt ^ r) & mask;
  endfunction

endpackage

// File: rtl/lbist_pat_counter.sv
// Pattern counter with terminal-count flag. 'last' is high while the count
// equals PAT_COUNT-1, so the owner can leave its loop before the count wraps.
module lbist_pat_counter #(
  parameter int PAT_COUNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(PAT_COUNT + 1);

  logic [CNT_W-1:0] cnt;

  // Count register: clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + CNT_W'(1);
  end

  assign last = (cnt == CNT_W'(PAT_COUNT - 1));

endmodule

// File: rtl/lbist_misr.sv
// LBIST MISR response compactor. Folds PAT_COUNT valid response words into
// an RC_BITS signature on rc_op and raises sig_valid once it is final.
// Optional macro LBIST_MISR_XMASK_EN adds resp_mask to zero unknown CUT bits.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int                 RC_BITS   = 8,
  parameter logic [RC_BITS-1:0] POLY      = RC_BITS'(POLY_8),
  parameter logic [RC_BITS-1:0] SEED      = '0,
  parameter int                 PAT_COUNT = PAT_COUNT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [RC_BITS-1:0] cut_resp,
  input  logic               resp_valid,
`ifdef LBIST_MISR_XMASK_EN
  input  logic [RC_BITS-1:0] resp_mask,
`endif
  output logic [RC_BITS-1:0] rc_op,
  output logic               sig_valid,
  output logic               busy
);

  misr_state_t        state;
  misr_state_t        state_next;
  logic               load;
  logic               absorb;
  logic               last;
  logic [RC_BITS-1:0] resp_in;
  logic [RC_BITS-1:0] rc_next;

`ifdef LBIST_MISR_XMASK_EN
  assign resp_in = cut_resp & ~resp_mask;
`else
  assign resp_in = cut_resp;
`endif

  assign load   = start && ((state == IDLE) || (state == DONE));
  assign absorb = (state == COMPACT) && resp_valid;

  assign rc_next = RC_BITS'(misr_step(MISR_MAX_BITS'(rc_op),
                                      MISR_MAX_BITS'(resp_in),
                                      MISR_MAX_BITS'(POLY),
                                      RC_BITS));

  lbist_pat_counter #(
    .PAT_COUNT(PAT_COUNT)
  ) u_pat_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(load),
    .inc  (absorb),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: start only honoured outside COMPACT.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = COMPACT;
      COMPACT: if (resp_valid && last) state_next = DONE;
      DONE:    if (start) state_next = COMPACT;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state alone.
  always_comb begin
    busy      = 1'b0;
    sig_valid = 1'b0;
    case (state)
      COMPACT: busy      = 1'b1;
      DONE:    sig_valid = 1'b1;
      default: ;
    endcase
  end

  // Signature register: reseed on a new session, fold valid words in COMPACT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rc_op <= SEED;
    else if (load)
      rc_op <= SEED;
    else if (absorb)
      rc_op <= rc_next;
  end

endmodule

// File: tb/tb_lbist_misr.sv
// Directed self-checking bench for lbist_misr with default parameters.
// Expected signatures are hand-derived: a 0x01 first word followed by zeros
// walks x^k mod x^8+x^4+x^3+x^2+1, ending at x^15 = 0x26.
`timescale 1ns/100ps
module tb_lbist_misr;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] cut_resp;
  logic       resp_valid;
  logic [7:0] rc_op;
  logic       sig_valid;
  logic       busy;
`ifdef LBIST_MISR_XMASK_EN
  logic [7:0] resp_mask;
`endif

  int checkCount = 0;
  int failCount  = 0;

  lbist_misr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cut_resp  (cut_resp),
    .resp_valid(resp_valid),
`ifdef LBIST_MISR_XMASK_EN
    .resp_mask (resp_mask),
`endif
    .rc_op     (rc_op),
    .sig_valid (sig_valid),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startSession();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends 16 valid words: w0 first, wLast last, zeros between. Optional
  // 3-cycle gaps after words gapA/gapB with the expected held signature,
  // and an optional start pulse alongside word startAt.
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] wLast,
                               input int gapA, input logic [7:0] gapValA,
                               input int gapB, input logic [7:0] gapValB,
                               input int startAt);
    for (int i = 1; i <= 16; i++) begin
      cut_resp   = (i == 1) ? w0 : ((i == 16) ? wLast : 8'h00);
      resp_valid = 1'b1;
      start      = (i == startAt);
      tick();
      start      = 1'b0;
      resp_valid = 1'b0;
      cut_resp   = 8'hA5;
      if (i == startAt) checkOutput("start_ignored_busy", busy, 1);
      if (i == 15) checkOutput("no_sig_before_last", sig_valid, 0);
      if (i == gapA || i == gapB) begin
        repeat (3) tick();
        checkOutput("gap_hold", rc_op, (i == gapA) ? gapValA : gapValB);
        checkOutput("gap_busy", busy, 1);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    cut_resp   = 8'h00;
    resp_valid = 1'b0;
`ifdef LBIST_MISR_XMASK_EN
    resp_mask  = 8'h00;
`endif
    #3;
    checkOutput("reset_rc_op", rc_op, 8'h00);
    checkOutput("reset_sig_valid", sig_valid, 0);
    checkOutput("reset_busy", busy, 0);
    #9 rst_n = 1'b1;
    tick();

    // Idle ignores response words.
    resp_valid = 1'b1; cut_resp = 8'h77;
    tick();
    resp_valid = 1'b0;
    checkOutput("idle_ignores_rc_op", rc_op, 8'h00);
    checkOutput("idle_ignores_busy", busy, 0);

    $display("[TB] Test 1: all-zero stream");
    startSession();
    checkOutput("t1_busy_after_start", busy, 1);
    applyStimulus(8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    checkOutput("t1_sig_valid", sig_valid, 1);
    checkOutput("t1_busy_low", busy, 0);
    checkOutput("t1_rc_op", rc_op, 8'h00);

    $display("[TB] Test 2: single 0x01 then zeros");
    startSession();
    applyStimulus(8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    checkOutput("t2_sig_valid", sig_valid, 1);
    checkOutput("t2_rc_op", rc_op, 8'h26);
    checkOutput("t2_comp_match", (rc_op == 8'h26), 1);
    checkOutput("t2_comp_miss", (rc_op == 8'hFC), 0);

    $display("[TB] Test 3: same stream with gaps");
    startSession();
    applyStimulus(8'h01, 8'h00, 4, 8'h08, 9, 8'h1D, 0);
    checkOutput("t3_sig_valid", sig_valid, 1);
    checkOutput("t3_rc_op", rc_op, 8'h26);

    $display("[TB] Test 4: start during COMPACT, then restart from DONE");
    startSession();
    applyStimulus(8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 5);
    checkOutput("t4_sig_valid", sig_valid, 1);
    checkOutput("t4_rc_op", rc_op, 8'h26);
    resp_valid = 1'b1; cut_resp = 8'hAA;
    repeat (3) tick();
    resp_valid = 1'b0;
    checkOutput("t4_done_hold_rc_op", rc_op, 8'h26);
    checkOutput("t4_done_hold_sig", sig_valid, 1);
    startSession();
    checkOutput("t4_restart_sig_low", sig_valid, 0);
    checkOutput("t4_restart_seed", rc_op, 8'h00);
    checkOutput("t4_restart_busy", busy, 1);
    applyStimulus(8'h00, 8'h5A, 0, 8'h00, 0, 8'h00, 0);
    checkOutput("t4_second_rc_op", rc_op, 8'h5A);
    checkOutput("t4_second_sig", sig_valid, 1);

    $display("[TB] Test 5: asynchronous reset mid-session");
    startSession();
    cut_resp = 8'h01; resp_valid = 1'b1;
    tick();
    cut_resp = 8'h00;
    repeat (4) tick();
    resp_valid = 1'b0;
    checkOutput("t5_partial_rc_op", rc_op, 8'h10);
    #2 rst_n = 1'b0;
    #0.5;
    checkOutput("t5_async_rc_op", rc_op, 8'h00);
    checkOutput("t5_async_sig", sig_valid, 0);
    checkOutput("t5_async_busy", busy, 0);
    #0.5 rst_n = 1'b1;
    resp_valid = 1'b1; cut_resp = 8'h33;
    repeat (3) tick();
    resp_valid = 1'b0;
    checkOutput("t5_stay_idle_busy", busy, 0);
    checkOutput("t5_stay_idle_rc_op", rc_op, 8'h00);
    checkOutput("t5_stay_idle_sig", sig_valid, 0);
    startSession();
    applyStimulus(8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    checkOutput("t5_recover_rc_op", rc_op, 8'h26);

`ifdef LBIST_MISR_XMASK_EN
    $display("[TB] Test 6: masked response bits");
    resp_mask = 8'hFE;
    startSession();
    applyStimulus(8'hFF, 8'hFE, 0, 8'h00, 0, 8'h00, 0);
    checkOutput("t6_masked_rc_op", rc_op, 8'h26);
    checkOutput("t6_masked_sig", sig_valid, 1);
    resp_mask = 8'h00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
